// File: rtl/sha256_rx_framer.sv
// Length-prefixed command framer: turns SOF/LEN_HI/LEN_LO/payload frames from the
// UART byte stream into start/data/last strobes for the SHA-256 processor.
module sha256_rx_framer #(
    parameter int CLK_FREQ      = 20_000_000,
    parameter int BAUD          = 115200,
    parameter int TIMEOUT_BYTES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       hash_busy,
    output logic       hash_start,
    output logic [7:0] data_in,
    output logic       data_valid,
    output logic       data_last,
    output logic       hash_abort,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       active
);

    localparam int BAUD_DIV    = CLK_FREQ / BAUD;
    localparam int TIMEOUT_CYC = TIMEOUT_BYTES * 10 * BAUD_DIV;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0]    SOF        = 8'h01;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN_HI  = 2'd1,
        LEN_LO  = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [TW-1:0] timer_q, timer_d;

    logic       start_d, valid_d, last_d, abort_d, err_d;
    logic [1:0] code_d;
    logic [7:0] data_d;
    logic [15:0] full_len;

    assign full_len = {len_q[15:8], rx_data};

    // A received byte always takes priority over the timer expiring in the same cycle.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        start_d     = 1'b0;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        abort_d     = 1'b0;
        err_d       = 1'b0;
        code_d      = err_code;
        data_d      = data_in;

        if (state_q == IDLE) begin
            timer_d = '0;
            if (rx_valid && rx_data == SOF) begin
                if (hash_busy) begin
                    err_d  = 1'b1;
                    code_d = 2'd3;
                end else begin
                    state_d = LEN_HI;
                end
            end
        end else if (rx_valid) begin
            timer_d = '0;
            case (state_q)
                LEN_HI: begin
                    len_d   = {rx_data, len_q[7:0]};
                    state_d = LEN_LO;
                end
                LEN_LO: begin
                    len_d = full_len;
                    if (full_len == 16'd0) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = IDLE;
                    end else begin
                        start_d     = 1'b1;
                        remaining_d = full_len;
                        state_d     = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    valid_d     = 1'b1;
                    data_d      = rx_data;
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end else if (timer_q == TIMER_LAST) begin
            // Only a frame that already issued hash_start has a partial message to discard.
            timer_d = '0;
            err_d   = 1'b1;
            code_d  = 2'd2;
            abort_d = (state_q == PAYLOAD);
            state_d = IDLE;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            hash_start  <= 1'b0;
            data_in     <= '0;
            data_valid  <= 1'b0;
            data_last   <= 1'b0;
            hash_abort  <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= '0;
            active      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            hash_start  <= start_d;
            data_in     <= data_d;
            data_valid  <= valid_d;
            data_last   <= last_d;
            hash_abort  <= abort_d;
            frame_err   <= err_d;
            err_code    <= code_d;
            active      <= (state_d != IDLE);
        end
    end

endmodule
